uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter between two byte FIFOs: source 0 is the RX echo/loopback FIFO and source 1 is the response FIFO. The block pops one byte at a time from the granted FIFO and covers the FIFO's one-cycle read latency. It then hands the byte to the transmitter with a start pulse and waits for the transmitter's busy signal to clear. Grants are round-robin, with a bounded burst per grant so neither source starves.

---
 rtl/uart_tx_arbiter.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter between two byte FIFOs:
//   source 0 = RX echo/loopback FIFO
//   source 1 = response FIFO
// Grants rotate round-robin. Each grant is limited to MAX_BURST bytes so
// that neither source can starve the other.
//
// Handshake rules
//   FIFO side: rdreq_x is a one-cycle pop pulse. The popped byte appears on
//     q_x in the following cycle. rdreq_x is only raised for a source whose
//     empty flag was sampled low, and this block is the FIFO's only reader.
//   TX side: tx_start is a one-cycle pulse, and tx_data is valid in that
//     cycle. The transmitter counts as free again once tx_busy reads low in
//     SEND. HOLD gives the transmitter one cycle to raise busy, so a slow
//     busy is never mistaken for completion.
//
// Byte flow per transfer: READ (pop) -> LATCH (capture q) -> LOAD (start)
//   -> HOLD -> SEND (wait for !busy).
module uart_tx_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              empty_0,
  input  logic [DATA_W-1:0] q_0,
  output logic              rdreq_0,
  input  logic              empty_1,
  input  logic [DATA_W-1:0] q_1,
  output logic              rdreq_1,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  output logic [1:0]        grant,
  output logic              active,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LATCH = 3'd2,
    S_LOAD  = 3'd3,
    S_HOLD  = 3'd4,
    S_SEND  = 3'd5
  } state_t;

  // Burst counter is 4 bits wide. MAX_BURST is limited to 1..15, so the
  // limit always fits in the counter.
  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);
  localparam logic [3:0] BURST_SAT = 4'hF;

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [3:0]        burst_q, burst_d;
  logic              last_q,  last_d;   // index of the source served last
  logic [DATA_W-1:0] data_q,  data_d;

  logic              req_0, req_1;
  logic              pick_1;
  logic              granted_empty;
  logic [DATA_W-1:0] granted_q;

  assign req_0 = ~empty_0;
  assign req_1 = ~empty_1;

  // Source selection and views of the currently granted FIFO.
  always_comb begin
    if (req_0 && req_1) begin
      pick_1 = ~last_q;           // tie: favour whoever was not served last
    end else begin
      pick_1 = req_1;
    end
    granted_empty = grant_q[1] ? empty_1 : empty_0;
    granted_q     = grant_q[1] ? q_1     : q_0;
  end

  // State and datapath registers; reset drops any byte in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      burst_q <= 4'd0;
      last_q  <= 1'b1;            // source 0 wins the first tie
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      burst_q <= burst_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic: arbitration, burst accounting and byte capture.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    burst_d = burst_q;
    last_d  = last_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (!tx_busy && (req_0 || req_1)) begin
          grant_d = pick_1 ? 2'b10 : 2'b01;
          burst_d = 4'd0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        data_d = granted_q;
        if (burst_q != BURST_SAT) begin
          burst_d = burst_q + 4'd1;
        end
        state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        // tx_busy may still be low here even though a frame was just started.
        state_d = S_SEND;
      end
      S_SEND: begin
        if (!tx_busy) begin
          if (!granted_empty && (burst_q < BURST_LIM)) begin
            state_d = S_READ;
          end else begin
            last_d  = grant_q[1];
            grant_d = 2'b00;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // Output decode. Pulses are masked during reset so none leak in that cycle.
  always_comb begin
    rdreq_0  = 1'b0;
    rdreq_1  = 1'b0;
    tx_start = 1'b0;
    if (!rst) begin
      if (state_q == S_READ) begin
        rdreq_0 = grant_q[0];
        rdreq_1 = grant_q[1];
      end
      tx_start = (state_q == S_LOAD);
    end
  end

  assign tx_data   = data_q;
  assign grant     = grant_q;
  assign active    = (state_q != S_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Bench for uart_tx_arbiter, built from these pieces:
//   - FIFO models with one-cycle read latency;
//   - a transmitter model whose busy either starts the cycle after tx_start
//     or in the same cycle;
//   - a round-robin reference model that predicts byte order and grant order
//     from the preloaded FIFO contents;
//   - a per-cycle monitor with a scoreboard and protocol checks;
//   - table vectors, hand-written corner sequences and random cases.
module tb_uart_tx_arbiter;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;
  localparam int MEM_N     = 4096;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              empty_0, empty_1, rdreq_0, rdreq_1;
  logic [DATA_W-1:0] q_0 = '0;
  logic [DATA_W-1:0] q_1 = '0;
  logic              tx_busy, tx_start, active;
  logic [DATA_W-1:0] tx_data;
  logic [1:0]        grant;
  logic [2:0]        state_dbg;

  uart_tx_arbiter #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .empty_0(empty_0), .q_0(q_0), .rdreq_0(rdreq_0),
    .empty_1(empty_1), .q_1(q_1), .rdreq_1(rdreq_1),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .grant(grant), .active(active), .state_dbg(state_dbg)
  );

  // ---------------- FIFO models ----------------
  logic [7:0] mem0[MEM_N];
  logic [7:0] mem1[MEM_N];
  int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
  assign empty_0 = (rd0 == wr0);
  assign empty_1 = (rd1 == wr1);

  always @(posedge clk) begin
    if (rdreq_0 && (rd0 != wr0)) begin
      q_0 <= mem0[rd0];
      rd0 <= rd0 + 1;
    end
    if (rdreq_1 && (rd1 != wr1)) begin
      q_1 <= mem1[rd1];
      rd1 <= rd1 + 1;
    end
  end

  // ---------------- transmitter model ----------------
  // tx_mode 1: busy is high for tx_len cycles, starting the cycle after start.
  // tx_mode 0: busy is high for tx_len cycles, starting with the start cycle.
  int tx_mode = 1, tx_len = 4, busy_cnt = 0;
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= (tx_mode == 0) ? tx_len - 1 : tx_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0) || ((tx_mode == 0) && tx_start);

  // ---------------- scoreboard state ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic [1:0]        exp_g[$];
  logic [1:0]        got_g[$];
  int n_cmp = 0, n_fail = 0;
  int cyc = 0, n_start = 0, n_rd0 = 0, n_rd1 = 0;
  int last_start = -100, last_rd = -100;
  bit pend = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_rst  = 1'b1;
  logic [1:0] prev_grant = 2'b00;
  bit done = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: round-robin with a per-grant burst limit, run over the
  // bytes still waiting in each FIFO. Source 0 wins the first tie.
  task automatic build_model();
    logic [7:0] s0[$];
    logic [7:0] s1[$];
    int last = 1;
    int src;
    int k;
    exp_q.delete();
    exp_g.delete();
    for (int i = rd0; i < wr0; i++) s0.push_back(mem0[i]);
    for (int i = rd1; i < wr1; i++) s1.push_back(mem1[i]);
    while (s0.size() > 0 || s1.size() > 0) begin
      if (s0.size() > 0 && s1.size() > 0) src = 1 - last;
      else src = (s0.size() > 0) ? 0 : 1;
      exp_g.push_back((src == 0) ? 2'b01 : 2'b10);
      k = 0;
      while (k < MAX_BURST && (((src == 0) ? s0.size() : s1.size()) > 0)) begin
        if (src == 0) exp_q.push_back(s0.pop_front());
        else          exp_q.push_back(s1.pop_front());
        k++;
      end
      last = src;
    end
  endtask

  // ---------------- monitor ----------------
  task automatic monitor();
    while (!done) begin
      @(negedge clk);
      cyc++;
      check("rdreq_both", {31'd0, rdreq_0 & rdreq_1}, 0);
      check("grant_onehot0", {31'd0, $onehot0(grant)}, 1);
      if (rdreq_0) begin
        n_rd0++;
        last_rd = cyc;
        check("rdreq_0_on_empty", {31'd0, empty_0}, 0);
      end
      if (rdreq_1) begin
        n_rd1++;
        last_rd = cyc;
        check("rdreq_1_on_empty", {31'd0, empty_1}, 0);
      end
      if (tx_data !== prev_data)
        check("tx_data_stable", {31'd0, tx_start | prev_rst}, 1);
      if (tx_start) begin
        check("start_spacing", {31'd0, (cyc - last_start) >= 5}, 1);
        check("start_while_busy", {31'd0, pend}, 0);
        check("read_to_start", cyc - last_rd, 2);
        if (exp_q.size() == 0) check("unexpected_start", {24'd0, tx_data}, 32'hFFFF_FFFF);
        else check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        n_start++;
        last_start = cyc;
        pend = 1'b1;
      end else if (pend && !tx_busy && (cyc > last_start + 1)) begin
        pend = 1'b0;
      end
      if (grant != prev_grant && grant != 2'b00) got_g.push_back(grant);
      prev_grant = grant;
      prev_data  = tx_data;
      prev_rst   = rst;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int src, input logic [7:0] b);
    if (src == 0) begin mem0[wr0] = b; wr0++; end
    else          begin mem1[wr1] = b; wr1++; end
  endtask

  task automatic start_case(input int mode, input int len);
    drive_edge();
    rst = 1'b1;
    tx_mode = mode;
    tx_len  = len;
    repeat (2) drive_edge();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && active == 1'b0 && !tx_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, {31'd0, n < budget}, 1);
  endtask

  task automatic finish_case(input string name, input int exp_starts);
    build_model();
    got_g.delete();
    n_start = 0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    wait_idle(name, 5000);
    repeat (3) @(negedge clk);
    check({name, "_starts"}, n_start, exp_starts);
    check({name, "_grant_cnt"}, got_g.size(), exp_g.size());
    for (int i = 0; i < got_g.size() && i < exp_g.size(); i++)
      check({name, "_grant_seq"}, {30'd0, got_g[i]}, {30'd0, exp_g[i]});
    check({name, "_end_grant"}, {30'd0, grant}, 0);
    check({name, "_end_active"}, {31'd0, active}, 0);
  endtask

  // ---------------- test vectors ----------------
  typedef struct {
    int         n0;
    int         n1;
    logic [7:0] b0;
    logic [7:0] b1;
    int         mode;
    int         len;
    int         exp_starts;
    int         exp_grants;
    logic [1:0] first_grant;
  } vec_t;

  task automatic main_seq();
    vec_t vt[6];
    int n, rn0, rn1;

    // Reset values while rst is held.
    start_case(1, 4);
    @(negedge clk);
    check("rst_rdreq_0", {31'd0, rdreq_0}, 0);
    check("rst_rdreq_1", {31'd0, rdreq_1}, 0);
    check("rst_tx_start", {31'd0, tx_start}, 0);
    check("rst_tx_data", {24'd0, tx_data}, 0);
    check("rst_grant", {30'd0, grant}, 0);
    check("rst_active", {31'd0, active}, 0);
    check("rst_state", {29'd0, state_dbg}, 0);
    drive_edge();
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_empty_active", {31'd0, active}, 0);

    // Single byte 0x41 from source 0.
    start_case(1, 6);
    load(0, 8'h41);
    build_model();
    got_g.delete();
    n_rd0 = 0; n_rd1 = 0; n_start = 0;
    rst = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rdreq_0 && n < 20);
    check("one_rdreq_seen", {31'd0, rdreq_0}, 1);
    repeat (2) @(negedge clk);
    check("one_start_lat", {31'd0, tx_start}, 1);
    check("one_data", {24'd0, tx_data}, 32'h41);
    check("one_grant_busy", {30'd0, grant}, 32'h1);
    n = 0;
    do begin @(negedge clk); n++; end while (!tx_busy && n < 10);
    do begin @(negedge clk); n++; end while (tx_busy && n < 40);
    check("one_busy_fell", {31'd0, tx_busy}, 0);
    check("one_grant_at_exit", {30'd0, grant}, 32'h1);
    @(negedge clk);
    check("one_grant_after", {30'd0, grant}, 0);
    check("one_active_after", {31'd0, active}, 0);
    repeat (4) @(negedge clk);
    check("one_rd0_cnt", n_rd0, 1);
    check("one_rd1_cnt", n_rd1, 0);
    check("one_start_cnt", n_start, 1);

    // Long busy: after the 20-cycle frame, READ follows 1 cycle after busy falls.
    start_case(1, 20);
    load(0, 8'h51);
    load(0, 8'h52);
    build_model();
    got_g.delete();
    n_start = 0;
    rst = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!tx_start && n < 20);
    check("long_first_start", {31'd0, tx_start}, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!rdreq_0 && n < 40);
    check("long_start_to_read", n, 22);
    wait_idle("long", 200);
    check("long_starts", n_start, 2);

    // Table-driven cases.
    vt[0] = '{6, 6, 8'h10, 8'h20, 1, 3, 12, 4, 2'b01};
    vt[1] = '{6, 6, 8'h10, 8'h20, 0, 3, 12, 4, 2'b01};
    vt[2] = '{0, 2, 8'h70, 8'h80, 1, 2, 2, 1, 2'b10};
    vt[3] = '{5, 0, 8'h30, 8'h00, 1, 2, 5, 2, 2'b01};
    vt[4] = '{3, 9, 8'h40, 8'h90, 0, 5, 12, 4, 2'b01};
    vt[5] = '{1, 1, 8'h60, 8'h61, 1, 20, 2, 2, 2'b01};
    for (int v = 0; v < 6; v++) begin
      start_case(vt[v].mode, vt[v].len);
      for (int i = 0; i < vt[v].n0; i++) load(0, 8'(vt[v].b0 + 8'(i)));
      for (int i = 0; i < vt[v].n1; i++) load(1, 8'(vt[v].b1 + 8'(i)));
      finish_case($sformatf("vec%0d", v), vt[v].exp_starts);
      check($sformatf("vec%0d_tbl_grants", v), got_g.size(), vt[v].exp_grants);
      if (got_g.size() > 0)
        check($sformatf("vec%0d_first_grant", v), {30'd0, got_g[0]}, {30'd0, vt[v].first_grant});
    end

    // Reset asserted in the LATCH cycle.
    start_case(1, 3);
    load(0, 8'hA1);
    load(0, 8'hA2);
    load(1, 8'hB1);
    build_model();
    rst = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rdreq_0 && n < 20);
    check("rl_rdreq_seen", {31'd0, rdreq_0}, 1);
    drive_edge();                 // now in LATCH
    rst = 1'b1;
    @(negedge clk);
    check("rl_no_start", {31'd0, tx_start}, 0);
    @(negedge clk);
    check("rl_state", {29'd0, state_dbg}, 0);
    check("rl_active", {31'd0, active}, 0);
    check("rl_grant", {30'd0, grant}, 0);
    check("rl_tx_data", {24'd0, tx_data}, 0);
    check("rl_rdreq", {30'd0, rdreq_1, rdreq_0}, 0);
    drive_edge();
    finish_case("rl", 2);
    check("rl_first_grant", {30'd0, got_g.size() > 0 ? got_g[0] : 2'b00}, 32'h1);

    // Randomized cases against the reference model.
    for (int r = 0; r < 20; r++) begin
      start_case($urandom_range(0, 1), $urandom_range(2, 8));
      rn0 = $urandom_range(0, 9);
      rn1 = $urandom_range(0, 9);
      for (int i = 0; i < rn0; i++) load(0, 8'($urandom));
      for (int i = 0; i < rn1; i++) load(1, 8'($urandom));
      finish_case($sformatf("rnd%0d", r), rn0 + rn1);
    end
    done = 1'b1;
  endtask

  // ---------------- run / final report ----------------
  initial begin
    fork
      monitor();
      main_seq();
      begin
        #900000;
        n_fail++;
        $display("FAIL global_timeout: bench did not complete by %0t", $time);
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
